control_barrera: RTL and testbench

//  Occupancy and barrier controller for the single-lane car park. Takes the one-cycle

---
 rtl/control_barrera_if.sv | 35 +++
 rtl/control_barrera.sv | 130 +++++++++++++
 tb/tb_control_barrera.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/control_barrera_if.sv
// Detector/request/barrier signal bundle for the car-park barrier controller.
// alarma is present only when ALARMA_EN is defined.
interface control_barrera_if #(
  parameter int ANCHO = 5
);
  logic             entrada;
  logic             salida;
  logic             pedido_ent;
  logic             pedido_sal;
  logic             barrera;
  logic             dir;
  logic [ANCHO-1:0] ocupados;
  logic             lleno;
  logic             vacio;
`ifdef ALARMA_EN
  logic             alarma;
`endif

  // master: detector and request side; slave: the controller
  modport master (
    output entrada, salida, pedido_ent, pedido_sal,
`ifdef ALARMA_EN
    input  alarma,
`endif
    input  barrera, dir, ocupados, lleno, vacio
  );

  modport slave (
    input  entrada, salida, pedido_ent, pedido_sal,
`ifdef ALARMA_EN
    output alarma,
`endif
    output barrera, dir, ocupados, lleno, vacio
  );
endinterface

// File: rtl/control_barrera.sv
// Occupancy counter and single-barrier arbiter/sequencer for a one-lane car park.
// Optional sticky tailgating/wrong-way alarm enabled by defining ALARMA_EN.
module control_barrera #(
  parameter int CAPACIDAD = 20,
  parameter int ANCHO     = 5,
  parameter int TIMEOUT   = 1000,
  parameter int CIERRE    = 50
) (
  input logic               clk,
  input logic               reset,
  control_barrera_if.slave  bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CW = (CIERRE > 1) ? $clog2(CIERRE) : 1;
  localparam logic [ANCHO-1:0] CAP     = ANCHO'(CAPACIDAD);
  localparam logic [TW-1:0]    T_ULT   = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0]    C_ULT   = CW'(CIERRE - 1);

  typedef enum logic [1:0] {LIBRE, ABIERTA, CERRANDO} estado_t;

  estado_t          state_q, state_d;
  logic             barrera_q, barrera_d;
  logic             dir_q, dir_d;
  logic [ANCHO-1:0] ocupados_q, ocupados_d;
  logic [TW-1:0]    t_abierta_q, t_abierta_d;
  logic [CW-1:0]    t_cierre_q, t_cierre_d;
  logic             lleno;
  logic             pulso_ok;

  assign lleno    = (ocupados_q == CAP);
  // the pulse that completes the currently granted passage
  assign pulso_ok = dir_q ? bus.salida : bus.entrada;

  always_comb begin
    ocupados_d = ocupados_q;
    if (bus.entrada && !bus.salida && ocupados_q != CAP)
      ocupados_d = ocupados_q + 1'b1;
    else if (bus.salida && !bus.entrada && ocupados_q != '0)
      ocupados_d = ocupados_q - 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    barrera_d   = barrera_q;
    dir_d       = dir_q;
    t_abierta_d = t_abierta_q;
    t_cierre_d  = t_cierre_q;
    case (state_q)
      LIBRE: begin
        barrera_d   = 1'b0;
        t_abierta_d = '0;
        // exit has priority; it also frees a space for a waiting entry
        if (bus.pedido_sal) begin
          dir_d     = 1'b1;
          barrera_d = 1'b1;
          state_d   = ABIERTA;
        end else if (bus.pedido_ent && !lleno) begin
          dir_d     = 1'b0;
          barrera_d = 1'b1;
          state_d   = ABIERTA;
        end
      end
      ABIERTA: begin
        t_abierta_d = t_abierta_q + 1'b1;
        if (pulso_ok || t_abierta_q == T_ULT) begin
          state_d    = CERRANDO;
          barrera_d  = 1'b0;
          t_cierre_d = '0;
        end
      end
      CERRANDO: begin
        barrera_d = 1'b0;
        if (t_cierre_q == C_ULT)
          state_d = LIBRE;
        else
          t_cierre_d = t_cierre_q + 1'b1;
      end
      default: begin
        state_d   = LIBRE;
        barrera_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LIBRE;
      barrera_q   <= 1'b0;
      dir_q       <= 1'b0;
      ocupados_q  <= '0;
      t_abierta_q <= '0;
      t_cierre_q  <= '0;
    end else begin
      state_q     <= state_d;
      barrera_q   <= barrera_d;
      dir_q       <= dir_d;
      ocupados_q  <= ocupados_d;
      t_abierta_q <= t_abierta_d;
      t_cierre_q  <= t_cierre_d;
    end
  end

  assign bus.barrera  = barrera_q;
  assign bus.dir      = dir_q;
  assign bus.ocupados = ocupados_q;
  assign bus.lleno    = lleno;
  assign bus.vacio    = (ocupados_q == '0);

`ifdef ALARMA_EN
  logic alarma_q, alarma_d;
  logic pulso_malo;

  // any pulse that is not the one completing the open grant
  assign pulso_malo = (bus.entrada && !(state_q == ABIERTA && !dir_q)) ||
                      (bus.salida  && !(state_q == ABIERTA &&  dir_q));

  always_comb begin
    alarma_d = alarma_q | pulso_malo;
  end

  always_ff @(posedge clk) begin
    if (reset) alarma_q <= 1'b0;
    else       alarma_q <= alarma_d;
  end

  assign bus.alarma = alarma_q;
`endif

endmodule

// File: tb/tb_control_barrera.sv
// Scoreboard bench for control_barrera: directed scenarios plus random traffic,
// checked against a countdown-based occupancy/barrier model.
module tb_control_barrera;
  localparam int CAP  = 20;
  localparam int AN   = 5;
  localparam int TOUT = 1000;
  localparam int CIE  = 50;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_barrera_if #(.ANCHO(AN)) bif ();

  control_barrera #(.CAPACIDAD(CAP), .ANCHO(AN), .TIMEOUT(TOUT), .CIERRE(CIE)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif.slave)
  );

  typedef struct {
    bit b;
    bit d;
    int occ;
    bit ll;
    bit va;
    bit al;
    int n;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // model: open countdown, close countdown, granted direction, count, alarm
  bit m_open, m_dir, m_al;
  int m_left, m_hold, m_cnt;

  task automatic chk(input string name, input int n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, n, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit e, input bit s, input bit pe, input bit ps);
    int  nc;
    bit  match, bad;
    exp_t x;
    if (r) begin
      m_open = 0; m_dir = 0; m_al = 0; m_left = 0; m_hold = 0; m_cnt = 0;
    end else begin
      nc    = m_cnt;
      match = m_open && ((!m_dir && e) || (m_dir && s));
      bad   = (e && !(m_open && !m_dir)) || (s && !(m_open && m_dir));
      if (e && !s)      nc = (m_cnt < CAP) ? m_cnt + 1 : CAP;
      else if (s && !e) nc = (m_cnt > 0) ? m_cnt - 1 : 0;
      if (bad) m_al = 1;
      if (m_open) begin
        if (match || m_left == 1) begin
          m_open = 0;
          m_hold = CIE;
        end else m_left--;
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (ps) begin
        m_open = 1; m_dir = 1; m_left = TOUT;
      end else if (pe && m_cnt < CAP) begin
        m_open = 1; m_dir = 0; m_left = TOUT;
      end
      m_cnt = nc;
    end
    x.b = m_open; x.d = m_dir; x.occ = m_cnt;
    x.ll = (m_cnt == CAP); x.va = (m_cnt == 0); x.al = m_al; x.n = cyc_n;
    q.push_back(x);
  endtask

  task automatic cyc(input bit r, input bit e, input bit s, input bit pe, input bit ps);
    @(negedge clk);
    reset = r; bif.entrada = e; bif.salida = s; bif.pedido_ent = pe; bif.pedido_sal = ps;
    @(posedge clk);
    cyc_n++;
    model(r, e, s, pe, ps);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // monitor: outputs are presented every cycle, compared against queued expectations
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("barrera",  e.n, int'(bif.barrera),  int'(e.b));
        chk("dir",      e.n, int'(bif.dir),      int'(e.d));
        chk("ocupados", e.n, int'(bif.ocupados), e.occ);
        chk("lleno",    e.n, int'(bif.lleno),    int'(e.ll));
        chk("vacio",    e.n, int'(bif.vacio),    int'(e.va));
`ifdef ALARMA_EN
        chk("alarma",   e.n, int'(bif.alarma),   int'(e.al));
`endif
      end
    end
  end

  initial begin
    bit pe, ps, e, s, r;
    reset = 1; bif.entrada = 0; bif.salida = 0; bif.pedido_ent = 0; bif.pedido_sal = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    // single entry: grant, pass, close hold
    cyc(0, 0, 0, 1, 0);
    idle(3);
    cyc(0, 1, 0, 0, 0);
    idle(CIE + 3);
    // fill to capacity
    while (m_cnt < CAP) begin
      cyc(0, 0, 0, 1, 0);
      cyc(0, 1, 0, 0, 0);
      idle(CIE + 1);
    end
    // full: entry waits, exit served even with both requested
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    idle(2);
    cyc(0, 0, 1, 0, 0);
    idle(CIE + 2);
    // entry granted and never completed: timeout
    cyc(0, 0, 0, 1, 0);
    idle(TOUT + CIE + 5);
    // wrong-direction pulse during open grant, then both pulses together
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(CIE + 2);
    // reset while open, then exit pulse at zero occupancy
    cyc(0, 0, 0, 1, 0);
    idle(2);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    // random traffic
    pe = 0; ps = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) pe = ~pe;
      if ($urandom_range(0, 29) == 0) ps = ~ps;
      e = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 11) == 0);
      r = ($urandom_range(0, 999) == 0);
      cyc(r, e, s, pe, ps);
    end
    idle(2);
    @(posedge clk);
    #3;
    chk("drained", cyc_n, q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
